// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone B4 widths and request/response bundles.
// Imported by the RAM, the interconnect and the peripherals.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef struct packed {
    logic [31:0]          adr;
    logic [WB_DATA_W-1:0] dat;
    logic [WB_SEL_W-1:0]  sel;
    logic                 we;
  } wb_req_t;

  typedef struct packed {
    logic [WB_DATA_W-1:0] dat;
    logic                 ack;
  } wb_rsp_t;

endpackage

// File: rtl/wb_ack_pipe.sv
// wb_ack_pipe: DEPTH-stage {valid, data} shift register feeding acks.
// Ports: clk_i, rst_i (sync, active-low), flush_i clears all valids,
// vld_i/dat_i enter stage 0, vld_o/dat_o leave the last stage
// (dat_o is 0 whenever vld_o is 0).
module wb_ack_pipe
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        vld_i,
  input  logic [31:0] dat_i,
  output logic        vld_o,
  output logic [31:0] dat_o
);

  logic [DEPTH-1:0]                vld_q;
  logic [DEPTH-1:0]                vld_d;
  logic [DEPTH-1:0][WB_DATA_W-1:0] dat_q;
  logic [DEPTH-1:0][WB_DATA_W-1:0] dat_d;

  always_comb begin
    vld_d    = '0;
    dat_d    = '0;
    vld_d[0] = vld_i;
    dat_d[0] = vld_i ? dat_i : '0;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    if (flush_i) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q[DEPTH-1];
  assign dat_o = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : '0;

endmodule

// File: rtl/wb_pipelined_ram.sv
// wb_pipelined_ram: pipelined Wishbone B4 slave RAM, byte-lane writes,
// fixed LATENCY acks, MAX_OUTSTANDING cap driving wb_stall_o.
// Ports: clk_i, rst_i (sync, active-low), wb_adr_i (byte address),
// wb_dat_i/wb_dat_o, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
// wb_ack_o, wb_stall_o.
module wb_pipelined_ram
  import wb_pkg::*;
#(
  parameter int ADDR_W          = 12,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_stall_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
    $error("wb_pipelined_ram: ADDR_W must be 1..29");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("wb_pipelined_ram: LATENCY must be 1..8");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY) begin : g_bad_max
    $error("wb_pipelined_ram: MAX_OUTSTANDING must be 1..LATENCY");
  end

  wb_req_t           req;
  wb_rsp_t           rsp;
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic [31:0]       rd_dat;
  logic              pipe_vld;
  logic [31:0]       pipe_dat;
  logic [CNT_W-1:0]  out_cnt_q;
  logic [CNT_W-1:0]  out_cnt_d;
  logic [31:0]       mem [DEPTH];
  logic              unused_adr;

  assign req = '{
    adr: wb_adr_i,
    dat: wb_dat_i,
    sel: wb_sel_i,
    we:  wb_we_i
  };

  // Upper and byte-offset address bits alias onto the same word.
  assign idx        = req.adr[ADDR_W+1:2];
  assign unused_adr = ^{req.adr[31:ADDR_W+2], req.adr[1:0]};

  // Stall comes from registered state only, so no stb->stall path.
  assign wb_stall_o = (out_cnt_q == CNT_MAX) && !wb_ack_o;
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o & rst_i;

  // Sampled at the accept edge; an earlier write is already in mem.
  assign rd_dat = req.we ? '0 : mem[idx];

  always_ff @(posedge clk_i) begin
    if (accept && req.we) begin
      for (int b = 0; b < WB_SEL_W; b++) begin
        if (req.sel[b]) begin
          mem[idx][8*b +: 8] <= req.dat[8*b +: 8];
        end
      end
    end
  end

  wb_ack_pipe #(
    .DEPTH (LATENCY)
  ) u_ack_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (~wb_cyc_i),
    .vld_i   (accept),
    .dat_i   (rd_dat),
    .vld_o   (pipe_vld),
    .dat_o   (pipe_dat)
  );

  assign rsp = '{
    dat: pipe_dat,
    ack: pipe_vld
  };

  assign wb_ack_o = rsp.ack;
  assign wb_dat_o = rsp.dat;

  always_comb begin
    out_cnt_d = out_cnt_q;
    unique case (1'b1)
      !wb_cyc_i: begin
        out_cnt_d = '0;
      end
      wb_cyc_i && accept && !wb_ack_o: begin
        out_cnt_d = out_cnt_q + CNT_ONE;
      end
      wb_cyc_i && !accept && wb_ack_o: begin
        out_cnt_d = out_cnt_q - CNT_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_cnt_q <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_pipelined_ram.sv
// tb_wb_pipelined_ram: four RAM configurations on one shared bus,
// each tracked by a queue-based reference model of pending acks.
module tb_wb_pipelined_ram;

  localparam int AW    = 12;
  localparam int NI    = 4;
  localparam int WORDS = 2 ** AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [31:0] d_o     [NI];
  logic        ack_o   [NI];
  logic        stall_o [NI];

  wb_pipelined_ram #(.ADDR_W(AW), .LATENCY(2), .MAX_OUTSTANDING(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_dat_o(d_o[0]), .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb),
    .wb_cyc_i(cyc), .wb_ack_o(ack_o[0]), .wb_stall_o(stall_o[0]));
  wb_pipelined_ram #(.ADDR_W(AW), .LATENCY(2), .MAX_OUTSTANDING(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_dat_o(d_o[1]), .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb),
    .wb_cyc_i(cyc), .wb_ack_o(ack_o[1]), .wb_stall_o(stall_o[1]));
  wb_pipelined_ram #(.ADDR_W(AW), .LATENCY(1), .MAX_OUTSTANDING(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_dat_o(d_o[2]), .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb),
    .wb_cyc_i(cyc), .wb_ack_o(ack_o[2]), .wb_stall_o(stall_o[2]));
  wb_pipelined_ram #(.ADDR_W(AW), .LATENCY(4), .MAX_OUTSTANDING(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_dat_o(d_o[3]), .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb),
    .wb_cyc_i(cyc), .wb_ack_o(ack_o[3]), .wb_stall_o(stall_o[3]));

  function automatic int lat_of(int i);
    case (i)
      0, 1:    return 2;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int max_of(int i);
    case (i)
      0:       return 2;
      1, 2:    return 1;
      default: return 3;
    endcase
  endfunction

  // Reference model: word array plus in-order queue of pending acks.
  logic [31:0] mm   [NI][WORDS];
  bit          mk   [NI][WORDS];
  int          qn   [NI];
  int          qdue [NI][8];
  logic [31:0] qdat [NI][8];
  bit          qkn  [NI][8];
  int          cyc_n;
  bit          live;

  logic        s_ack    [NI];
  logic        s_stall  [NI];
  logic [31:0] s_dat    [NI];
  bit          last_acc [NI];
  logic [31:0] pre      [64];

  int n_chk;
  int n_fail;

  function automatic void chk(string nm, int i, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d: got %h expected %h", nm, i, act, exp);
    end
  endfunction

  function automatic void chk1(string nm, int i, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d: got %b expected %b", nm, i, act, exp);
    end
  endfunction

  function automatic bit m_ack(int i);
    return qn[i] > 0 && qdue[i][0] == cyc_n;
  endfunction

  function automatic bit m_stall(int i);
    return qn[i] == max_of(i) && !m_ack(i);
  endfunction

  task automatic tick();
    bit acc [NI];
    bit ak  [NI];
    int w;
    for (int i = 0; i < NI; i++) begin
      ak[i]      = m_ack(i);
      acc[i]     = cyc && stb && rst && !m_stall(i);
      s_ack[i]   = ack_o[i];
      s_dat[i]   = d_o[i];
      s_stall[i] = stall_o[i];
      if (live) begin
        chk1("ack", i, ack_o[i], ak[i]);
        chk1("stall", i, stall_o[i], m_stall(i));
        if (!ak[i]) chk("dat_idle", i, d_o[i], 32'h0);
        else if (qkn[i][0]) chk("rdata", i, d_o[i], qdat[i][0]);
      end
    end
    @(posedge clk);
    cyc_n++;
    w = int'(adr[AW+1:2]);
    for (int i = 0; i < NI; i++) begin
      last_acc[i] = acc[i];
      if (!rst || !cyc) begin
        qn[i] = 0;
      end else begin
        if (ak[i]) begin
          for (int j = 0; j < qn[i] - 1; j++) begin
            qdue[i][j] = qdue[i][j+1];
            qdat[i][j] = qdat[i][j+1];
            qkn[i][j]  = qkn[i][j+1];
          end
          qn[i]--;
        end
        if (acc[i]) begin
          qdue[i][qn[i]] = cyc_n + lat_of(i) - 1;
          qdat[i][qn[i]] = we ? 32'h0 : mm[i][w];
          qkn[i][qn[i]]  = we ? 1'b0 : mk[i][w];
          qn[i]++;
          if (we) begin
            for (int b = 0; b < 4; b++) begin
              if (sel[b]) mm[i][w][8*b +: 8] = dat[8*b +: 8];
            end
            if (sel == 4'hF) mk[i][w] = 1'b1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    stb = 1'b0;
    repeat (n) tick();
  endtask

  // One transaction on the bus, targeting instance t's handshake.
  task automatic xfer(input int t, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int lat,
                      output bit ok);
    int n;
    cyc = 1'b1;
    stb = 1'b1;
    we  = w;
    adr = a;
    dat = d;
    sel = s;
    n   = 0;
    do begin
      tick();
      n++;
    end while (!last_acc[t] && n < 20);
    stb = 1'b0;
    ok  = 1'b0;
    lat = 0;
    rd  = 32'h0;
    if (!last_acc[t]) return;
    for (int k = 1; k <= 20 && !ok; k++) begin
      tick();
      if (s_ack[t]) begin
        ok  = 1'b1;
        lat = k;
        rd  = s_dat[t];
      end
    end
  endtask

  task automatic stream(input int t, input int base, input int gap,
                        output int nst, output int nack,
                        output int nbad, output int ngap);
    int iss;
    int prevc;
    bit was;
    iss  = 0;
    nst  = 0;
    nack = 0;
    nbad = 0;
    ngap = 0;
    prevc = 0;
    cyc = 1'b1;
    we  = 1'b0;
    sel = 4'hF;
    dat = 32'h0;
    stb = 1'b1;
    for (int k = 0; k < 80 && nack < 8; k++) begin
      was = stb;
      if (stb) adr = 32'((base + iss) * 4);
      tick();
      if (was && s_stall[t]) nst++;
      if (s_ack[t]) begin
        if (s_dat[t] !== pre[base + nack]) nbad++;
        if (nack > 0 && k - prevc != gap) ngap++;
        prevc = k;
        nack++;
      end
      if (was && last_acc[t]) begin
        iss++;
        if (iss == 8) stb = 1'b0;
      end
    end
    stb = 1'b0;
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] rdv;
    logic [31:0] r;
    int          lat;
    int          n;
    int          nst;
    int          nack;
    int          nbad;
    int          ngap;
    bit          ok;

    n_chk  = 0;
    n_fail = 0;
    cyc_n  = 0;
    live   = 1'b0;
    for (int i = 0; i < NI; i++) qn[i] = 0;

    tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 32'h0};
    tbl[3] = '{1'b1, 32'h0000_0020, 32'h000000AA, 4'h1, 32'h0};
    tbl[4] = '{1'b1, 32'h0000_0020, 32'hBB000000, 4'h8, 32'h0};
    tbl[5] = '{1'b0, 32'h0000_0020, 32'h0,        4'hF, 32'hBB2233AA};
    tbl[6] = '{1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'h0, 32'h0};
    tbl[7] = '{1'b0, 32'h0000_0020, 32'h0,        4'h0, 32'hBB2233AA};
    tbl[8] = '{1'b1, 32'h8000_0024, 32'h01020304, 4'hF, 32'h0};
    tbl[9] = '{1'b0, 32'h0000_0027, 32'h0,        4'hF, 32'h01020304};

    rst = 1'b0;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    adr = 32'h0;
    dat = 32'h0;
    sel = 4'h0;
    tick();
    tick();
    live = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk1("rst_ack", i, s_ack[i], 1'b0);
      chk1("rst_stall", i, s_stall[i], 1'b0);
      chk("rst_dat", i, s_dat[i], 32'h0);
    end
    rst = 1'b1;
    cyc = 1'b1;

    for (int i = 0; i < 64; i++) begin
      pre[i] = $urandom();
      xfer(0, 1'b1, 32'(i * 4), pre[i], 4'hF, rd, lat, ok);
      if (!ok) chk1("preload_to", i, ok, 1'b1);
    end
    idle(6);

    for (int v = 0; v < 10; v++) begin
      xfer(0, tbl[v].w, tbl[v].a, tbl[v].d, tbl[v].s, rd, lat, ok);
      chk1("tbl_ok", v, ok, 1'b1);
      if (!tbl[v].w) begin
        chk("tbl_rd", v, rd, tbl[v].exp);
        chk("tbl_lat", v, 32'(lat), 32'd2);
      end
      idle(3);
    end

    idle(6);
    cyc = 1'b1;
    stb = 1'b1;
    we  = 1'b1;
    adr = 32'h0000_4010;
    dat = 32'hCAFEF00D;
    sel = 4'hF;
    tick();
    chk1("raw_wacc", 0, last_acc[0], 1'b1);
    we  = 1'b0;
    adr = 32'h0000_0010;
    dat = 32'h0;
    tick();
    chk1("raw_racc", 0, last_acc[0], 1'b1);
    stb = 1'b0;
    n   = 0;
    rdv = 32'h0;
    repeat (8) begin
      tick();
      if (s_ack[0]) begin
        n++;
        if (n == 2) rdv = s_dat[0];
      end
    end
    chk("raw_nack", 0, 32'(n), 32'd2);
    chk("raw_dat", 0, rdv, 32'hCAFEF00D);

    idle(8);
    stream(0, 32, 1, nst, nack, nbad, ngap);
    chk("s0_stalls", 0, 32'(nst), 32'd0);
    chk("s0_nack", 0, 32'(nack), 32'd8);
    chk("s0_order", 0, 32'(nbad), 32'd0);
    chk("s0_gap", 0, 32'(ngap), 32'd0);

    idle(8);
    stream(1, 32, 2, nst, nack, nbad, ngap);
    chk("s1_stalls", 1, 32'(nst), 32'd7);
    chk("s1_nack", 1, 32'(nack), 32'd8);
    chk("s1_order", 1, 32'(nbad), 32'd0);
    chk("s1_gap", 1, 32'(ngap), 32'd0);

    idle(8);
    cyc = 1'b1;
    stb = 1'b1;
    we  = 1'b0;
    sel = 4'hF;
    for (int k = 0; k < 3; k++) begin
      adr = 32'(32'h80 + 4 * k);
      tick();
      chk1("ab_acc", 3, last_acc[3], 1'b1);
    end
    cyc = 1'b0;
    stb = 1'b0;
    tick();
    chk1("ab_stall_pre", 3, s_stall[3], 1'b1);
    chk("ab_cnt", 3, 32'(dut3.out_cnt_q), 32'd0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) chk1("ab_stall_post", 3, s_stall[3], 1'b0);
      if (s_ack[3]) n++;
    end
    chk("ab_noack", 3, 32'(n), 32'd0);
    xfer(3, 1'b0, 32'h80, 32'h0, 4'hF, rd, lat, ok);
    chk1("ab_ok", 3, ok, 1'b1);
    chk("ab_rd", 3, rd, pre[32]);
    chk("ab_lat", 3, 32'(lat), 32'd4);

    idle(8);
    xfer(0, 1'b1, 32'h40, 32'h5A5A1234, 4'hF, rd, lat, ok);
    chk1("rs_wok", 0, ok, 1'b1);
    idle(6);
    cyc = 1'b1;
    stb = 1'b1;
    we  = 1'b0;
    adr = 32'h40;
    tick();
    chk1("rs_acc", 0, last_acc[0], 1'b1);
    stb = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin
        for (int i = 0; i < NI; i++) begin
          chk1("rs_ack0", i, s_ack[i], 1'b0);
          chk1("rs_stall0", i, s_stall[i], 1'b0);
        end
      end
      if (s_ack[0]) n++;
    end
    chk("rs_noack", 0, 32'(n), 32'd0);
    xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, rd, lat, ok);
    chk1("rs_rok", 0, ok, 1'b1);
    chk("rs_rd", 0, rd, 32'h5A5A1234);

    idle(8);
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 99) >= 2);
      cyc = ($urandom_range(0, 99) >= 4);
      stb = ($urandom_range(0, 99) < 70);
      we  = 1'($urandom_range(0, 1));
      r   = $urandom();
      adr = {r[31:14], 6'b0, 6'($urandom_range(0, 63)), r[1:0]};
      dat = $urandom();
      sel = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b1;
    cyc = 1'b1;
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_pipelined_ram.md
Name: wb_pipelined_ram

Overview:
Pipelined Wishbone B4 slave memory directly downstream of the ecap5_dproc master bus, serving both instruction fetches and load/store accesses. Word-organised RAM with byte-select writes and a fixed, parameterised read/ack latency. A configurable cap on outstanding requests drives wb_stall_o. Used as boot/program memory in benches and small SoC builds.

Parameters:
ADDR_W, 12, word-address width; memory holds 2**ADDR_W 32-bit words.
LATENCY, 2, cycles from accept edge to ack cycle; legal range 1..8.
MAX_OUTSTANDING, 2, maximum accepted-but-unacknowledged requests; legal range 1..LATENCY.

Ports:
clk_i  in  1  clock, all logic rising-edge.
rst_i  in  1  synchronous, active-low reset (0 = reset).
wb_adr_i  in  32  byte address; bits [ADDR_W+1:2] select the word; other bits ignored, so addresses alias.
wb_dat_i  in  32  write data.
wb_dat_o  out  32  read data, valid while wb_ack_o=1.
wb_sel_i  in  4  byte lane enables; bit n covers dat[8n+7:8n].
wb_we_i  in  1  1 = write, 0 = read.
wb_stb_i  in  1  request strobe.
wb_cyc_i  in  1  bus cycle active.
wb_ack_o  out  1  one-cycle acknowledge per accepted request.
wb_stall_o  out  1  request not accepted this cycle.

Behaviour:
- Accept: a request is accepted at an edge where wb_cyc_i & wb_stb_i & !wb_stall_o & rst_i are all 1. At most one request is accepted per cycle.
- Write: committed to the array at the accept edge. Only lanes with wb_sel_i=1 are updated; sel=0000 is a valid no-op write and is still acked.
- Read: the array word is sampled at the accept edge and returns the full 32 bits regardless of wb_sel_i.
- Read-after-write: a read accepted on the edge after a write to the same word returns the new data.
- Latency: for a request accepted at edge k, wb_ack_o=1 for exactly one cycle, starting after edge k+LATENCY-1. With LATENCY=1, the ack appears in the cycle directly after acceptance.
- Ordering: acks are returned strictly in order. Back-to-back accepts produce back-to-back acks.
- wb_dat_o: driven 0 whenever wb_ack_o=0.
- Outstanding counter: out_cnt, width clog2(MAX_OUTSTANDING+1).
  - Increments on accept.
  - Decrements when an ack is issued.
  - Both in the same cycle leaves it unchanged.
- Stall: wb_stall_o = (out_cnt == MAX_OUTSTANDING) & !ack_retiring_this_cycle. It is combinational from registered state only; there is no path from wb_stb_i.
- With MAX_OUTSTANDING=LATENCY: never stalls in steady streaming.
- With MAX_OUTSTANDING<LATENCY: bubbles appear, giving throughput MAX_OUTSTANDING/LATENCY.
- cyc abort: wb_cyc_i=0 at any edge flushes every in-flight pipeline slot and clears out_cnt to 0.
  - No acks are delivered for flushed requests.
  - Writes already committed stay committed.
  - wb_stall_o drops to 0 the following cycle.
- stb without cyc: ignored; not accepted.
- Reset (rst_i=0):
  - All pipeline valid bits and out_cnt clear to 0.
  - wb_ack_o=0, wb_dat_o=0, wb_stall_o=0 from the cycle after the reset edge.
  - Array contents are not cleared.
  - Reset mid-operation drops all in-flight acks; no request is accepted on a reset edge.
- Reset release: the first accept is possible at the first edge with rst_i=1.
- Illegal parameters: the block raises an elaboration-time error.

Decomposition:
- Shared package (wb_pkg):
  - Constants WB_DATA_W=32 and WB_SEL_W=4.
  - Typedef wb_req_t {adr, dat, sel, we}.
  - Typedef wb_rsp_t {dat, ack}.
  - Reused later by the interconnect and the peripherals.
- Sub-module wb_ack_pipe:
  - LATENCY-deep shift register of {valid, data[31:0]} with a synchronous flush input.
  - Outputs the retiring valid and data.
- Top level (wb_pipelined_ram) holds the array, the byte-lane write, out_cnt and stall logic.

Test Plan:
1. Reset, then write 0xDEADBEEF to 0x0000_0010 with sel=1111, then read 0x10 with LATENCY=2 -> the read ack appears 2 cycles after its accept with wb_dat_o=0xDEADBEEF, and wb_dat_o=0 in every non-ack cycle.
2. Byte lanes: preload 0x11223344 at 0x20, then write 0x000000AA with sel=0001, then write 0xBB000000 with sel=1000, then read -> 0xBB2233AA. A sel=0000 write is acked and leaves the data unchanged.
3. Streaming: 8 back-to-back reads with LATENCY=2, MAX_OUTSTANDING=2 -> stall stays 0 throughout, 8 consecutive acks arrive in address order. Repeat with MAX_OUTSTANDING=1 -> stall alternates and exactly one ack arrives every 2 cycles.
4. Aliasing and RAW: write 0xCAFEF00D to 0x0000_4010 with ADDR_W=12, then read 0x0000_0010 on the very next edge -> returns 0xCAFEF00D.
5. cyc abort: accept 2 reads, then drop wb_cyc_i before the first ack -> no ack is ever seen, out_cnt=0, stall=0 next cycle. A subsequent read returns correct data with normal latency.
6. Reset mid-flight: accept a read, then assert rst_i=0 for 1 cycle before the ack -> no ack appears. Data written before the reset remains readable afterwards.
